// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave: accepts one req at a time, responds LATENCY+1 cycles later
// with a one-cycle ready pulse; illegal (misaligned / out-of-range) accesses complete with err.
module data_mem_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [15:0] wr_count
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [31:0] mem_q [WORDS];
  logic [31:0] mem_d [WORDS];

  logic                  legal;
  logic [DEPTH_LOG2-1:0] widx;

  // Legality is judged on the latched address, so bus changes mid-transaction cannot affect it.
  assign legal = (addr_q[1:0] == 2'b00) && ((addr_q >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign widx  = addr_q[DEPTH_LOG2+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    wr_count_d = wr_count_q;
    mem_d      = mem_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end

      RESP: begin
        // Memory, rdata and ready all update on the edge that leaves RESP.
        state_d = IDLE;
        ready_d = 1'b1;
        err_d   = !legal;
        if (legal) begin
          if (we_q) begin
            mem_d[widx] = wdata_q;
            wr_count_d  = wr_count_q + 16'd1;
          end else begin
            rdata_d = mem_q[widx];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      wr_count_q <= 16'd0;
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two instances (LATENCY=2 and LATENCY=0) driven with directed and random
// accesses; expected responses come from an array-based memory model and are checked by a monitor.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ready_s [2];
  logic        err_s   [2];
  logic [15:0] wrc_s   [2];

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(2), .DEPTH_LOG2(6)) u_dut_l2 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]),
    .wr_count(wrc_s[0])
  );

  data_mem_responder #(.LATENCY(0), .DEPTH_LOG2(6)) u_dut_l0 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]),
    .wr_count(wrc_s[1])
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [15:0] wrc;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // reference model: plain word array per instance
  logic [31:0] mem_m [2][64];
  logic [15:0] wrc_m [2];
  logic [31:0] rd_m  [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [inst%0d]: actual %h required %h at cycle %0d", nm, k, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mem_m[k][i] = 32'd0;
      wrc_m[k] = 16'd0;
      rd_m[k]  = 32'd0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic push_exp(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input int acc);
    exp_t e;
    bit   ok;
    ok = (a % 4 == 0) && (a < 32'd256);
    e.err = !ok;
    if (ok && w) begin
      mem_m[k][a / 4] = wd;
      wrc_m[k] = wrc_m[k] + 16'd1;
    end else if (ok) begin
      rd_m[k] = mem_m[k][a / 4];
    end
    e.rdata = rd_m[k];
    e.wrc   = wrc_m[k];
    e.acc   = acc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge where ready is seen.
  task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, output int rdy_cyc);
    bit got;
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = wd;
    @(posedge clk);
    #1;
    push_exp(k, w, a, wd, cyc);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_s[k]) begin
        got = 1'b1;
        break;
      end
      req_s[k] = 1'($urandom); we_s[k] = 1'($urandom);
      addr_s[k] = $urandom;    wdata_s[k] = $urandom;
    end
    rdy_cyc = cyc;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout [inst%0d]: actual no ready required ready within 40 cycles", k);
    end
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < 2; k++) req_s[k] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) req_s[k] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] gen_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return ({26'd0, 6'($urandom_range(0, 63))} << 2) | 32'($urandom_range(1, 3));
    if (r < 6)  return 32'($urandom_range(0, 7)) << 2;
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (!ready_s[k]) begin
          chk("err_without_ready", k, 32'(err_s[k]), 32'd0);
        end else begin
          exp_t e;
          bit   have;
          have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ready [inst%0d]: actual ready=1 required no pulse, cycle %0d", k, cyc);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("latency", k, 32'(cyc - e.acc), 32'(lat_of(k) + 1));
            chk("err", k, 32'(err_s[k]), 32'(e.err));
            chk("rdata", k, rdata_s[k], e.rdata);
            chk("wr_count", k, 32'(wrc_s[k]), 32'(e.wrc));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, c;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", k, 32'(ready_s[k]), 32'd0);
      chk("reset_err", k, 32'(err_s[k]), 32'd0);
      chk("reset_rdata", k, rdata_s[k], 32'd0);
      chk("reset_wr_count", k, 32'(wrc_s[k]), 32'd0);
    end

    // basic write/read, then illegal accesses
    do_txn(0, 1'b1, 32'h54, 32'h7, c);
    gap(1);
    do_txn(0, 1'b0, 32'h54, 32'h0, c);
    gap(1);
    do_txn(0, 1'b1, 32'h06, 32'h1234_5678, c);
    gap(1);
    do_txn(0, 1'b0, 32'h04, 32'h0, c);
    gap(1);
    do_txn(0, 1'b1, 32'h100, 32'hCAFE_F00D, c);
    gap(1);
    do_txn(0, 1'b0, 32'h00, 32'h0, c);
    gap(1);

    // req held high: back-to-back writes, then write followed immediately by read of same word
    do_txn(0, 1'b1, 32'h10, 32'h1111_1111, c1);
    do_txn(0, 1'b1, 32'h14, 32'h2222_2222, c2);
    do_txn(0, 1'b1, 32'h18, 32'h3333_3333, c3);
    chk("b2b_gap1", 0, 32'(c2 - c1), 32'(lat_of(0) + 2));
    chk("b2b_gap2", 0, 32'(c3 - c2), 32'(lat_of(0) + 2));
    do_txn(0, 1'b1, 32'h20, 32'hA5A5_5A5A, c);
    do_txn(0, 1'b0, 32'h20, 32'h0, c);
    gap(2);

    // reset while a write sits in WAIT: aborted, nothing written, no pulse
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h08; wdata_s[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_s[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    gap(6);
    chk("abort_wr_count", 0, 32'(wrc_s[0]), 32'd0);
    do_txn(0, 1'b0, 32'h08, 32'h0, c);
    gap(1);

    // zero-latency instance: read after reset
    do_txn(1, 1'b0, 32'h00, 32'h0, c);
    gap(1);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < ((k == 0) ? 80 : 50); n++) begin
        do_txn(k, 1'($urandom_range(0, 1)), gen_addr(), $urandom, c);
        if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
      end
      gap(2);
    end

    gap(6);
    chk("q0_drained", 0, 32'(q0.size()), 32'd0);
    chk("q1_drained", 1, 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
